// File: rtl/fifo_mac_pkg.sv
// Shared types and defaults for the fifo_mac multiply-accumulate consumer.
// Optional feature macro: FIFO_MAC_SAT_EN (saturating accumulator).
package fifo_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fifo_mac_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 24;
    localparam int DEF_COUNT      = 8;

    // Wide enough to hold the value COUNT itself, not just COUNT-1.
    function automatic int count_width(input int count);
        return $clog2(count + 1);
    endfunction

endpackage

// File: rtl/fifo_mac_mac_pipe.sv
// Two-stage multiply/accumulate datapath: product register, accumulator, accumulate counter.
// Defining FIFO_MAC_SAT_EN makes the accumulator saturate instead of wrapping.
module mac_pipe
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH  = count_width(DEF_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    fire,
    input  logic [DATA_WIDTH-1:0]   a_data,
    input  logic [DATA_WIDTH-1:0]   b_data,
    output logic [ACC_WIDTH-1:0]    acc,
    output logic [CNT_WIDTH-1:0]    acc_cnt,
    output logic                    prod_vld
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    acc_next;

`ifdef FIFO_MAC_SAT_EN
    logic [ACC_WIDTH:0] sum;

    // A carry out of the top bit pins the accumulator at all-ones; further adds keep it there.
    always_comb begin
        sum      = {1'b0, acc} + (ACC_WIDTH + 1)'(prod);
        acc_next = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
    end
`else
    always_comb begin
        acc_next = acc + ACC_WIDTH'(prod);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod     <= '0;
            prod_vld <= 1'b0;
            acc      <= '0;
            acc_cnt  <= '0;
        end else begin
            prod     <= a_data * b_data;
            prod_vld <= fire;
            if (clear) begin
                acc     <= '0;
                acc_cnt <= '0;
            end else if (prod_vld) begin
                acc     <= acc_next;
                acc_cnt <= acc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_mac.sv
// Lockstep consumer of two show-ahead FIFOs: sums COUNT products a*b and pulses done.
// Saturation instead of wrap is selected by defining FIFO_MAC_SAT_EN.
module fifo_mac
    import fifo_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int COUNT      = DEF_COUNT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a_data,
    input  logic                    a_empty,
    output logic                    a_rden,
    input  logic [DATA_WIDTH-1:0]   b_data,
    input  logic                    b_empty,
    output logic                    b_rden,
    output logic [ACC_WIDTH-1:0]    result,
    output logic                    done,
    output logic                    busy
);

    localparam int                CW      = count_width(COUNT);
    localparam logic [CW-1:0]     COUNT_C = CW'(COUNT);
    localparam logic [CW-1:0]     LAST_C  = CW'(COUNT - 1);

    fifo_mac_state_t state;
    logic [CW-1:0]   issued;
    logic [CW-1:0]   acc_cnt;
    logic            prod_vld;
    logic            fire;
    logic            clear;

    assign fire   = (state == RUN) && !a_empty && !b_empty && (issued < COUNT_C);
    assign clear  = (state == IDLE) && start;
    assign a_rden = fire && rst_n;
    assign b_rden = fire && rst_n;
    assign busy   = (state != IDLE);

    // FLUSH stays put through the done cycle so busy covers it and start is ignored there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            issued <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        issued <= '0;
                    end
                end
                RUN: begin
                    if (fire) begin
                        issued <= issued + 1'b1;
                        if (issued == LAST_C) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (done) state <= IDLE;
                    else if (prod_vld && acc_cnt == LAST_C) done <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mac_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .CNT_WIDTH  (CW)
    ) u_mac_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .fire     (fire),
        .a_data   (a_data),
        .b_data   (b_data),
        .acc      (result),
        .acc_cnt  (acc_cnt),
        .prod_vld (prod_vld)
    );

endmodule
